// File: rtl/musician_pkg.sv
// rtl/musician_pkg.sv - shared note table, widths and player state encoding
package musician_pkg;
    localparam int NOTE_W    = 3;
    localparam int HALF_W    = 17;
    localparam int NUM_NOTES = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Half-period in clock cycles at 50 MHz, C4 up to C5.
    localparam logic [HALF_W-1:0] NOTE_DIV [NUM_NOTES] = '{
        17'd95556, 17'd85131, 17'd75843, 17'd71586,
        17'd63776, 17'd56818, 17'd50619, 17'd47778
    };

    function automatic logic [HALF_W-1:0] half_period(input logic [NOTE_W-1:0] idx);
        return NOTE_DIV[idx];
    endfunction
endpackage

// File: rtl/note_queue_player_if.sv
// rtl/note_queue_player_if.sv - key strobe and audio bundle for note_queue_player
interface note_queue_player_if #(
    parameter int NUM_KEYS   = 8,
    parameter int FIFO_DEPTH = 8
);
    import musician_pkg::*;

    logic [NUM_KEYS-1:0]         key_pulse;
    logic                        tone_out;
    logic                        playing;
    logic [NOTE_W-1:0]           cur_note;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        overflow;

    modport master (output key_pulse, input tone_out, playing, cur_note, fifo_count, overflow);
    modport slave  (input key_pulse, output tone_out, playing, cur_note, fifo_count, overflow);
endinterface

// File: rtl/note_fifo.sv
// rtl/note_fifo.sv - note index queue; a pop in the same cycle lets a full queue accept a push
module note_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             do_push, do_pop;

    // DEPTH is a power of two, so the count MSB is set only when full.
    assign full     = count_q[AW];
    assign empty    = (count_q == '0);
    assign dout     = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

    always_comb begin
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        overflow_d = push && !do_push;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: rtl/note_queue_player.sv
// rtl/note_queue_player.sv - key strobe encoder, note queue and square-wave player
// Define NOTE_GAP_EN to insert GAP_CYCLES of silence after every note.
module note_queue_player
    import musician_pkg::*;
#(
    parameter int NUM_KEYS    = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int NOTE_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 2500000
) (
    input  logic               clock,
    input  logic               reset,
    note_queue_player_if.slave bus
);
    localparam int DUR_MAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int DUR_W   = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q, state_d;
    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
    logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
    logic              tone_q, tone_d;
    logic              playing_q, playing_d;
    logic [NOTE_W-1:0] cur_note_q, cur_note_d;

    logic              push;
    logic [NOTE_W-1:0] push_note;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              unused_full;
    logic              fifo_overflow;
    logic [NOTE_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;

    always_comb begin
        push      = |bus.key_pulse;
        push_note = '0;
        // Scan from the top so the lowest set bit wins.
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (bus.key_pulse[i]) push_note = NOTE_W'(i);
        end
    end

    note_fifo #(
        .WIDTH (NOTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (fifo_pop),
        .din      (push_note),
        .dout     (fifo_head),
        .count    (fifo_count),
        .full     (unused_full),
        .empty    (fifo_empty),
        .overflow (fifo_overflow)
    );

    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        tone_d     = tone_q;
        playing_d  = playing_q;
        cur_note_d = cur_note_q;
        fifo_pop   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tone_d    = 1'b0;
                playing_d = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    cur_note_d = fifo_head;
                    half_cnt_d = '0;
                    dur_cnt_d  = '0;
                    tone_d     = 1'b1;
                    playing_d  = 1'b1;
                    state_d    = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (half_cnt_q == half_period(cur_note_q) - 1'b1) begin
                    tone_d     = !tone_q;
                    half_cnt_d = '0;
                end else begin
                    half_cnt_d = half_cnt_q + 1'b1;
                end
                if (dur_cnt_q == DUR_W'(NOTE_CYCLES - 1)) begin
                    tone_d    = 1'b0;
                    playing_d = 1'b0;
                    dur_cnt_d = '0;
`ifdef NOTE_GAP_EN
                    state_d   = ST_GAP;
`else
                    state_d   = ST_IDLE;
`endif
                end else begin
                    dur_cnt_d = dur_cnt_q + 1'b1;
                end
            end
`ifdef NOTE_GAP_EN
            ST_GAP: begin
                tone_d    = 1'b0;
                playing_d = 1'b0;
                if (dur_cnt_q == DUR_W'(GAP_CYCLES - 1)) begin
                    dur_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    dur_cnt_d = dur_cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            half_cnt_q <= '0;
            dur_cnt_q  <= '0;
            tone_q     <= 1'b0;
            playing_q  <= 1'b0;
            cur_note_q <= '0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
            tone_q     <= tone_d;
            playing_q  <= playing_d;
            cur_note_q <= cur_note_d;
        end
    end

    assign bus.tone_out   = tone_q;
    assign bus.playing    = playing_q;
    assign bus.cur_note   = cur_note_q;
    assign bus.fifo_count = fifo_count;
    assign bus.overflow   = fifo_overflow;
endmodule

// File: tb/tb_note_queue_player.sv
// tb/tb_note_queue_player.sv - scoreboard bench for note_queue_player
module tb_note_queue_player;
    localparam int A_NOTE_CYCLES = 57000;
    localparam int B_NOTE_CYCLES = 1000;
    localparam int B_GAP_CYCLES  = 50;
`ifdef NOTE_GAP_EN
    localparam int EXP_GAP = B_GAP_CYCLES + 1;
`else
    localparam int EXP_GAP = 1;
`endif
    localparam int EXP_HALF_5 = 56818;

    logic clock = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   sb[$];

    int   a_strobe = 0;
    int   a_rise = 0;
    int   a_fall = 0;
    int   a_toggle = 0;
    logic [2:0] a_note = '0;
    logic a_play_prev = 1'b0;
    logic a_tone_prev = 1'b0;
    int   b_ovf_cnt = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    note_queue_player_if #(.NUM_KEYS(8), .FIFO_DEPTH(8)) a_if ();
    note_queue_player_if #(.NUM_KEYS(8), .FIFO_DEPTH(8)) b_if ();

    note_queue_player #(
        .NUM_KEYS(8), .FIFO_DEPTH(8), .NOTE_CYCLES(A_NOTE_CYCLES), .GAP_CYCLES(B_GAP_CYCLES)
    ) u_a (
        .clock (clock),
        .reset (rst_a_n),
        .bus   (a_if.slave)
    );

    note_queue_player #(
        .NUM_KEYS(8), .FIFO_DEPTH(8), .NOTE_CYCLES(B_NOTE_CYCLES), .GAP_CYCLES(B_GAP_CYCLES)
    ) u_b (
        .clock (clock),
        .reset (rst_b_n),
        .bus   (b_if.slave)
    );

    always @(negedge clock) begin
        if (a_if.playing === 1'b1 && a_play_prev === 1'b0 && a_rise == 0) begin
            a_rise = cyc;
            a_note = a_if.cur_note;
        end
        if (a_if.playing === 1'b1 && a_tone_prev === 1'b1 && a_if.tone_out === 1'b0 && a_toggle == 0)
            a_toggle = cyc;
        if (a_if.playing === 1'b0 && a_play_prev === 1'b1 && a_fall == 0)
            a_fall = cyc;
        a_play_prev = a_if.playing;
        a_tone_prev = a_if.tone_out;
    end

    always @(negedge clock) begin
        if (b_if.overflow === 1'b1) b_ovf_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pop_exp();
        if (sb.size() == 0) return -1;
        return sb.pop_front();
    endfunction

    task automatic wait_playing(input logic lvl, input int max_cyc, output int at_cyc, output logic tone_seen);
        int n;
        n = 0;
        tone_seen = 1'b0;
        while (b_if.playing !== lvl && n < max_cyc) begin
            if (b_if.tone_out !== 1'b0) tone_seen = 1'b1;
            @(negedge clock);
            n++;
        end
        at_cyc = cyc;
        check(lvl ? "wait_rise" : "wait_fall", {31'd0, b_if.playing === lvl}, 32'd1);
    endtask

    initial begin
        int   rise;
        int   fall;
        int   t;
        int   note;
        logic tone_seen;

        a_if.key_pulse = '0;
        b_if.key_pulse = '0;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_tone", b_if.tone_out, 0);
        check("rst_playing", b_if.playing, 0);
        check("rst_cur_note", b_if.cur_note, 0);
        check("rst_count", b_if.fifo_count, 0);
        check("rst_overflow", b_if.overflow, 0);
        check("rst_a_tone", a_if.tone_out, 0);
        check("rst_a_playing", a_if.playing, 0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            check("idle_tone", b_if.tone_out, 0);
            check("idle_playing", b_if.playing, 0);
            check("idle_count", b_if.fifo_count, 0);
        end

        a_if.key_pulse = 8'b0010_0000;
        a_strobe = cyc + 1;
        @(negedge clock);
        a_if.key_pulse = '0;
        check("a_count_after_strobe", a_if.fifo_count, 1);

        t = b_ovf_cnt;
        b_if.key_pulse = 8'b0010_0100;
        sb.push_back(2);
        @(negedge clock);
        b_if.key_pulse = '0;
        check("enc_count", b_if.fifo_count, 1);
        check("enc_playing_early", b_if.playing, 0);
        @(negedge clock);
        check("enc_playing", b_if.playing, 1);
        check("enc_note", b_if.cur_note, pop_exp());
        check("enc_count_after_pop", b_if.fifo_count, 0);
        rise = cyc;
        wait_playing(1'b0, B_NOTE_CYCLES + 10, fall, tone_seen);
        check("enc_duration", fall - rise, B_NOTE_CYCLES);
        check("enc_no_overflow", b_ovf_cnt - t, 0);
        repeat (B_GAP_CYCLES + 10) @(negedge clock);

        b_if.key_pulse = 8'b0000_1000;
        @(negedge clock);
        b_if.key_pulse = 8'b1000_0000;
        @(negedge clock);
        b_if.key_pulse = '0;
        check("mid_playing", b_if.playing, 1);
        check("mid_note", b_if.cur_note, 3);
        check("mid_count", b_if.fifo_count, 1);
        repeat (5) @(negedge clock);
        check("mid_tone_high", b_if.tone_out, 1);
        #2 rst_b_n = 1'b0;
        #1;
        check("async_rst_tone", b_if.tone_out, 0);
        check("async_rst_playing", b_if.playing, 0);
        check("async_rst_count", b_if.fifo_count, 0);
        @(negedge clock);
        rst_b_n = 1'b1;
        repeat (3) @(negedge clock);
        check("flushed_idle", b_if.playing, 0);

        t = b_ovf_cnt;
        b_if.key_pulse = 8'b0100_0000;
        sb.push_back(6);
        @(negedge clock);
        b_if.key_pulse = '0;
        @(negedge clock);
        check("fill_first_playing", b_if.playing, 1);
        check("fill_first_note", b_if.cur_note, pop_exp());
        rise = cyc;
        for (int i = 0; i < 9; i++) begin
            note = (i < 8) ? i : 1;
            b_if.key_pulse = 8'(1 << note);
            if (i < 8) sb.push_back(note);
            @(negedge clock);
            check("fill_count", b_if.fifo_count, (i < 8) ? i + 1 : 8);
            check("fill_overflow", b_if.overflow, (i == 8) ? 1 : 0);
        end
        b_if.key_pulse = '0;
        @(negedge clock);
        check("ovf_one_cycle", b_if.overflow, 0);
        check("ovf_pulses", b_ovf_cnt - t, 1);

        wait_playing(1'b0, B_NOTE_CYCLES + 10, fall, tone_seen);
        check("note6_duration", fall - rise, B_NOTE_CYCLES);
        repeat (EXP_GAP - 1) @(negedge clock);
        check("full_before_pp", b_if.fifo_count, 8);
        b_if.key_pulse = 8'b0001_0000;
        sb.push_back(4);
        @(negedge clock);
        b_if.key_pulse = '0;
        check("pp_playing", b_if.playing, 1);
        check("pp_count", b_if.fifo_count, 8);
        check("pp_overflow", b_if.overflow, 0);
        check("pp_note", b_if.cur_note, pop_exp());
        rise = cyc;
        check("pp_gap", rise - fall, EXP_GAP);

        for (int k = 0; k < 8; k++) begin
            wait_playing(1'b0, B_NOTE_CYCLES + 10, fall, tone_seen);
            check("drain_duration", fall - rise, B_NOTE_CYCLES);
            wait_playing(1'b1, EXP_GAP + 10, rise, tone_seen);
            check("gap_len", rise - fall, EXP_GAP);
            check("gap_tone", {31'd0, tone_seen}, 0);
            check("play_order", b_if.cur_note, pop_exp());
        end
        wait_playing(1'b0, B_NOTE_CYCLES + 10, fall, tone_seen);
        check("last_duration", fall - rise, B_NOTE_CYCLES);
        check("drained_count", b_if.fifo_count, 0);
        check("sb_empty", sb.size(), 0);
        check("total_ovf", b_ovf_cnt - t, 1);

        t = 0;
        while (a_fall == 0 && t < 70000) begin
            @(negedge clock);
            t++;
        end
        check("a_done", {31'd0, a_fall != 0}, 1);
        check("a_latency", a_rise - a_strobe, 1);
        check("a_note", a_note, 5);
        check("a_half_period", a_toggle - a_rise, EXP_HALF_5);
        check("a_duration", a_fall - a_rise, A_NOTE_CYCLES);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
